// File: rtl/output_writeback.sv
// output_writeback: takes result words from the co-processor, optionally clamps
// negatives to +0.0, buffers them in a small FIFO and writes them to consecutive
// output-memory addresses starting at a configured base. A one-cycle finish_sig
// pulse follows the write that commits the last configured word.
module output_writeback #(
    parameter int DATAWIDTH   = 32,
    parameter int O_ADDRWIDTH = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_sig,
    input  logic [O_ADDRWIDTH-1:0] cfg_base_addr,
    input  logic [O_ADDRWIDTH:0]   cfg_num,
    input  logic                   cfg_relu_en,
    input  logic                   in_valid,
    input  logic [DATAWIDTH-1:0]   in_data,
    output logic                   in_ready,
    output logic                   mem_wr_en,
    output logic [O_ADDRWIDTH-1:0] mem_wr_addr,
    output logic [DATAWIDTH-1:0]   mem_wr_data,
    input  logic                   mem_wr_ready,
    output logic                   busy,
    output logic                   finish_sig
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int NW = O_ADDRWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [O_ADDRWIDTH-1:0] base_q;
    logic [NW-1:0]          num_q;
    logic                   relu_q;
    logic [NW-1:0]          acc_cnt;
    logic [NW-1:0]          wr_cnt;

    logic [DATAWIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [DATAWIDTH-1:0]   push_data;
    logic [NW-1:0]          wr_cnt_next;

    // Handshakes, status flags and the write port, all derived from registered state
    always_comb begin
        fifo_full   = (count == CW'(FIFO_DEPTH));
        fifo_empty  = (count == '0);
        in_ready    = (state == S_RUN) && !fifo_full && (acc_cnt < num_q);
        mem_wr_en   = (state == S_RUN) && !fifo_empty;
        mem_wr_data = mem_wr_en ? fifo_mem[rd_ptr] : '0;
        mem_wr_addr = base_q + wr_cnt[O_ADDRWIDTH-1:0];
        push        = in_valid && in_ready;
        pop         = mem_wr_en && mem_wr_ready;
        push_data   = (relu_q && in_data[DATAWIDTH-1]) ? '0 : in_data;
        wr_cnt_next = wr_cnt + NW'(1);
        busy        = (state == S_RUN);
        finish_sig  = (state == S_DONE);
    end

    // Layer control: configuration latch, beat/write counters and state sequencing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            relu_q  <= 1'b0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_sig) begin
                        base_q  <= cfg_base_addr;
                        num_q   <= cfg_num;
                        relu_q  <= cfg_relu_en;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        state   <= (cfg_num == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        acc_cnt <= acc_cnt + NW'(1);
                    end
                    if (pop) begin
                        wr_cnt <= wr_cnt_next;
                        if (wr_cnt_next == num_q) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a reset discards any buffered words
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the read port is gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback: directed layers from the test plan
// followed by randomized layers, all checked every cycle against a scoreboard model.
module tb_output_writeback;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int NW    = AW + 1;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_sig = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [NW-1:0] cfg_num = '0;
    logic          cfg_relu_en = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_ready = 1'b0;
    logic          busy;
    logic          finish_sig;

    always #5 clk = ~clk;

    output_writeback #(
        .DATAWIDTH  (DW),
        .O_ADDRWIDTH(AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_sig    (start_sig),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num      (cfg_num),
        .cfg_relu_en  (cfg_relu_en),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .busy         (busy),
        .finish_sig   (finish_sig)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int passed = 0;
    int total  = 0;

    // Reference model: layer status plus the ordered list of writes still owed
    bit            m_busy = 1'b0;
    bit            m_fin  = 1'b0;
    bit            m_relu = 1'b0;
    logic [AW-1:0] m_base = '0;
    int            m_num  = 0;
    int            acc    = 0;
    int            wr     = 0;
    wr_t           exp_q[$];
    logic [DW-1:0] src_q[$];
    int unsigned   vprob = 100;
    int unsigned   rprob = 100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_wr_en"}, 64'(mem_wr_en), 64'(0));
        check({tag, "_wr_addr"}, 64'(mem_wr_addr), 64'(0));
        check({tag, "_wr_data"}, 64'(mem_wr_data), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_finish"}, 64'(finish_sig), 64'(0));
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_fin  = 1'b0;
        acc    = 0;
        wr     = 0;
        exp_q.delete();
        src_q.delete();
    endtask

    // One clock: drive inputs, check at the falling edge, advance the model
    task automatic cycle();
        int  occ;
        bit  acc_ev;
        bit  wr_ev;
        wr_t e;
        in_valid     = (src_q.size() > 0) && ($urandom_range(99) < vprob);
        in_data      = (src_q.size() > 0) ? src_q[0] : $urandom();
        mem_wr_ready = ($urandom_range(99) < rprob);
        @(negedge clk);
        occ = acc - wr;
        check("busy", 64'(busy), 64'(m_busy));
        check("finish", 64'(finish_sig), 64'(m_fin));
        check("in_ready", 64'(in_ready), 64'(m_busy && occ < DEPTH && acc < m_num));
        check("wr_en", 64'(mem_wr_en), 64'(m_busy && occ > 0));
        if (mem_wr_en && exp_q.size() > 0) begin
            check("wr_addr", 64'(mem_wr_addr), 64'(exp_q[0].a));
            check("wr_data", 64'(mem_wr_data), 64'(exp_q[0].d));
        end
        acc_ev = in_valid && in_ready;
        wr_ev  = mem_wr_en && mem_wr_ready;
        if (acc_ev) begin
            e.a = m_base + AW'(acc);
            e.d = (m_relu && in_data[DW-1]) ? '0 : in_data;
            exp_q.push_back(e);
            void'(src_q.pop_front());
            acc++;
        end
        if (wr_ev) begin
            check("write_owed", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            wr++;
        end
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (!m_busy) begin
            if (start_sig) begin
                m_base = cfg_base_addr;
                m_num  = int'(cfg_num);
                m_relu = cfg_relu_en;
                acc    = 0;
                wr     = 0;
                exp_q.delete();
                if (m_num == 0) m_fin = 1'b1;
                else            m_busy = 1'b1;
            end
        end else if (wr_ev && wr == m_num) begin
            m_busy = 1'b0;
            m_fin  = 1'b1;
        end
        @(posedge clk);
        #1;
        start_sig = 1'b0;
    endtask

    task automatic run_layer(input logic [AW-1:0] base, input int num, input bit relu,
                             input int stall, input bit mid_start);
        int          n;
        int unsigned saved;
        cfg_base_addr = base;
        cfg_num       = NW'(num);
        cfg_relu_en   = relu;
        start_sig     = 1'b1;
        cycle();
        cfg_base_addr = AW'($urandom());
        cfg_num       = NW'($urandom_range(50, 1));
        cfg_relu_en   = 1'($urandom());
        n = 0;
        while ((m_busy || m_fin) && n < 400) begin
            saved = rprob;
            if (n < stall) rprob = 0;
            if (mid_start && n == 2) start_sig = 1'b1;
            cycle();
            rprob = saved;
            n++;
            if (stall > 0 && n == stall)
                check("stall_accepts", 64'(acc), 64'((num < DEPTH) ? num : DEPTH));
        end
        check("layer_done", 64'(!(m_busy || m_fin)), 64'(1));
    endtask

    initial begin
        int            n;
        int            num;
        logic [DW-1:0] w;

        // Reset values
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        repeat (2) cycle();

        // Basic path
        vprob = 100; rprob = 100;
        src_q = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h00000000};
        run_layer(16'h0100, 4, 1'b0, 0, 1'b0);
        src_q.delete();

        // ReLU clamp including -0.0
        src_q = '{32'hC0000000, 32'h80000000, 32'h3F000000};
        run_layer(16'h2000, 3, 1'b1, 0, 1'b0);
        src_q.delete();

        // Backpressure: FIFO fills to 8 while memory stalls for 20 cycles
        for (int i = 0; i < 12; i++) src_q.push_back($urandom());
        run_layer(16'h0400, 12, 1'b0, 20, 1'b0);
        src_q.delete();

        // Address wrap, then zero-length layer
        for (int i = 0; i < 4; i++) src_q.push_back($urandom());
        run_layer(16'hFFFE, 4, 1'b0, 0, 1'b0);
        src_q.delete();
        for (int i = 0; i < 3; i++) src_q.push_back($urandom());
        run_layer(16'h1234, 0, 1'b0, 0, 1'b0);
        check("zero_num_no_accepts", 64'(src_q.size()), 64'(3));
        src_q.delete();

        // Excess beats offered, start pulse during RUN
        for (int i = 0; i < 5; i++) src_q.push_back($urandom());
        run_layer(16'h0800, 2, 1'b0, 3, 1'b1);
        check("excess_left", 64'(src_q.size()), 64'(3));
        src_q.delete();
        repeat (2) cycle();

        // Reset in the middle of a layer
        for (int i = 0; i < 6; i++) src_q.push_back($urandom());
        cfg_base_addr = 16'h3000;
        cfg_num       = NW'(6);
        cfg_relu_en   = 1'b0;
        start_sig     = 1'b1;
        cycle();
        n = 0;
        while (wr < 3 && n < 50) begin
            cycle();
            n++;
        end
        check("midreset_reached", 64'(wr), 64'(3));
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) cycle();
        for (int i = 0; i < 5; i++) src_q.push_back($urandom());
        run_layer(16'h5000, 5, 1'b0, 0, 1'b0);
        src_q.delete();

        // Randomized layers with random valid/ready duty cycles
        for (int k = 0; k < 10; k++) begin
            num = int'($urandom_range(24, 1));
            for (int i = 0; i < num + 3; i++) begin
                w = $urandom();
                src_q.push_back(w);
            end
            vprob = $urandom_range(100, 30);
            rprob = $urandom_range(100, 30);
            run_layer(AW'($urandom()), num, 1'($urandom()), 0, 1'($urandom()));
            src_q.delete();
            repeat (int'($urandom_range(3, 0))) cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
